fpga_input_conditioner: RTL and testbench

//  Synchronises and debounces the raw board pushbuttons and slide switches in the cgm_clk domain.
//  Its outputs drive the HPS-visible PIO inputs button_pio_export[3:0] and dipsw_pio_export[9:0]
//  of soc_system, so software reads clean, glitch-free levels.

---
 rtl/fpga_input_cond_pkg.sv | 14 +
 rtl/fpga_input_conditioner_debounce_bit.sv | 84 ++++++++
 rtl/fpga_input_conditioner.sv | 77 +++++++
 tb/tb_fpga_input_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_input_cond_pkg.sv
// Shared types and defaults for the board input conditioner.
package fpga_input_cond_pkg;

    typedef enum logic {ST_STABLE, ST_SETTLING} db_state_t;

    localparam int unsigned DEF_DB_CYCLES   = 500000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Counter width able to hold the value db_cycles without wrapping.
    function automatic int unsigned db_cnt_width(input int unsigned db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/fpga_input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain, optional polarity inversion, and a debounce FSM.
// The registered level only follows the synchronised input once it has held for
// DB_CYCLES+1 consecutive FSM evaluations; any bounce back restarts the settle.
module debounce_bit
    import fpga_input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter bit          IDLE_LVL    = 1'b0,
    parameter bit          INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = db_cnt_width(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;

    // Synchroniser chain; reset preloads the idle pin level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Normalise polarity after the chain so the synchroniser sees the raw pin.
    assign s = INVERT ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    // Debounce FSM state, counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Next-state: count while the input disagrees, commit at DB_CYCLES, drop on bounce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            ST_STABLE: begin
                if (s != level_q) begin
                    state_d = ST_SETTLING;
                    cnt_d   = CW'(1);
                end
            end
            ST_SETTLING: begin
                if (s == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DB_CYCLES)) begin
                    level_d = s;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;

endmodule

// File: rtl/fpga_input_conditioner.sv
// Synchronises and debounces board buttons and switches for the HPS PIO inputs.
// Optional edge pulses (btn_press, sw_change) are built when FPGA_INPUT_COND_EDGE_EN
// is defined; otherwise those ports are tied low and no edge registers exist.
module fpga_input_conditioner
    import fpga_input_cond_pkg::*;
#(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned N_SW           = 10,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned DB_CYCLES      = DEF_DB_CYCLES,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             cgm_clk,
    input  logic             rgm_reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_SW-1:0]  sw_out,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_SW-1:0]  sw_change
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .IDLE_LVL    (BTN_ACTIVE_LOW),
            .INVERT      (BTN_ACTIVE_LOW)
        ) u_db (
            .clk   (cgm_clk),
            .rst   (rgm_reset),
            .raw   (btn_raw[i]),
            .level (btn_out[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .IDLE_LVL    (1'b0),
            .INVERT      (1'b0)
        ) u_db (
            .clk   (cgm_clk),
            .rst   (rgm_reset),
            .raw   (sw_raw[i]),
            .level (sw_out[i])
        );
    end

`ifdef FPGA_INPUT_COND_EDGE_EN
    logic [N_BTN-1:0] btn_prev_q, btn_press_q;
    logic [N_SW-1:0]  sw_prev_q, sw_change_q;

    // Registered previous-value compare; pulse lands the cycle after the level moves.
    always_ff @(posedge cgm_clk) begin
        if (rgm_reset) begin
            btn_prev_q  <= '0;
            btn_press_q <= '0;
            sw_prev_q   <= '0;
            sw_change_q <= '0;
        end else begin
            btn_prev_q  <= btn_out;
            btn_press_q <= btn_out & ~btn_prev_q;
            sw_prev_q   <= sw_out;
            sw_change_q <= sw_out ^ sw_prev_q;
        end
    end

    assign btn_press = btn_press_q;
    assign sw_change = sw_change_q;
`else
    assign btn_press = '0;
    assign sw_change = '0;
`endif

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Self-checking bench for fpga_input_conditioner with DB_CYCLES=8, SYNC_STAGES=2.
// Expected output changes are queued when stimulus is driven and applied on their cycle.
module tb_fpga_input_conditioner;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_SW  = 10;
    localparam int unsigned LAT   = 10;  // SYNC_STAGES + DB_CYCLES

`ifdef FPGA_INPUT_COND_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic             cgm_clk = 1'b0;
    logic             rgm_reset;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_out, btn_press;
    logic [N_SW-1:0]  sw_out, sw_change;

    always #5 cgm_clk = ~cgm_clk;

    fpga_input_conditioner #(
        .N_BTN          (N_BTN),
        .N_SW           (N_SW),
        .SYNC_STAGES    (2),
        .DB_CYCLES      (8),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .cgm_clk   (cgm_clk),
        .rgm_reset (rgm_reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_out   (btn_out),
        .sw_out    (sw_out),
        .btn_press (btn_press),
        .sw_change (sw_change)
    );

    typedef enum int {F_BTN, F_SW, F_PRESS, F_CHG} field_t;
    typedef struct {
        int     at;
        field_t f;
        int     idx;
        logic   val;
    } ev_t;

    ev_t              evq[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [N_BTN-1:0] exp_btn   = '0;
    logic [N_BTN-1:0] exp_press = '0;
    logic [N_SW-1:0]  exp_sw    = '0;
    logic [N_SW-1:0]  exp_chg   = '0;

    task automatic push_ev(input int at, input field_t f, input int idx, input logic val);
        ev_t e;
        e.at  = at;
        e.f   = f;
        e.idx = idx;
        e.val = val;
        evq.push_back(e);
    endtask

    // A one-cycle edge pulse is only expected when the edge logic is built.
    task automatic push_pulse(input int at, input field_t f, input int idx);
        if (EDGE_EN) begin
            push_ev(at, f, idx, 1'b1);
            push_ev(at + 1, f, idx, 1'b0);
        end
    endtask

    // Advance one clock, retire queued expectations due at this edge, sample at negedge.
    task automatic step();
        @(posedge cgm_clk);
        cyc++;
        for (int i = 0; i < evq.size();) begin
            if (evq[i].at == cyc) begin
                case (evq[i].f)
                    F_BTN:   exp_btn[evq[i].idx]   = evq[i].val;
                    F_SW:    exp_sw[evq[i].idx]    = evq[i].val;
                    F_PRESS: exp_press[evq[i].idx] = evq[i].val;
                    default: exp_chg[evq[i].idx]   = evq[i].val;
                endcase
                evq.delete(i);
            end else begin
                i++;
            end
        end
        @(negedge cgm_clk);
    endtask

    task automatic test_reset();
        rgm_reset = 1'b1;
        btn_raw   = 4'hF;
        sw_raw    = '0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) rgm_reset = 1'b0;
            step();
            checks++;
            if ({btn_out, sw_out, btn_press, sw_change} !== {exp_btn, exp_sw, exp_press, exp_chg})
            begin
                errors++;
                $display("FAIL reset cyc=%0d got btn=%h sw=%h prs=%h chg=%h want %h %h %h %h",
                         cyc, btn_out, sw_out, btn_press, sw_change,
                         exp_btn, exp_sw, exp_press, exp_chg);
            end
        end
    endtask

    task automatic test_clean_press(input string tag);
        int t0;
        btn_raw[0] = 1'b0;
        t0 = cyc + 1;
        push_ev(t0 + LAT, F_BTN, 0, 1'b1);
        push_pulse(t0 + LAT + 1, F_PRESS, 0);
        for (int i = 0; i < 27; i++) begin
            if (i == 14) begin
                btn_raw[0] = 1'b1;
                t0 = cyc + 1;
                push_ev(t0 + LAT, F_BTN, 0, 1'b0);
            end
            step();
            checks++;
            if ({btn_out, btn_press} !== {exp_btn, exp_press}) begin
                errors++;
                $display("FAIL %s cyc=%0d got btn_out=%h btn_press=%h want %h %h",
                         tag, cyc, btn_out, btn_press, exp_btn, exp_press);
            end
            checks++;
            if ({sw_out, sw_change} !== {exp_sw, exp_chg}) begin
                errors++;
                $display("FAIL %s_sw cyc=%0d got sw_out=%h sw_change=%h want %h %h",
                         tag, cyc, sw_out, sw_change, exp_sw, exp_chg);
            end
        end
    endtask

    task automatic test_bounce();
        int t0;
        int pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) sw_raw[3] = ~sw_raw[3];
            step();
            checks++;
            if ({sw_out, sw_change} !== {exp_sw, exp_chg}) begin
                errors++;
                $display("FAIL bounce_toggle cyc=%0d got sw_out=%h sw_change=%h want %h %h",
                         cyc, sw_out, sw_change, exp_sw, exp_chg);
            end
        end
        sw_raw[3] = 1'b1;
        t0 = cyc + 1;
        push_ev(t0 + LAT, F_SW, 3, 1'b1);
        push_pulse(t0 + LAT + 1, F_CHG, 3);
        for (int i = 0; i < 27; i++) begin
            if (i == 14) begin
                sw_raw[3] = 1'b0;
                t0 = cyc + 1;
                push_ev(t0 + LAT, F_SW, 3, 1'b0);
                push_pulse(t0 + LAT + 1, F_CHG, 3);
            end
            step();
            if (i < 14 && sw_change[3] === 1'b1) pulses++;
            checks++;
            if ({btn_out, sw_out, btn_press, sw_change} !== {exp_btn, exp_sw, exp_press, exp_chg})
            begin
                errors++;
                $display("FAIL bounce_settle cyc=%0d got btn=%h sw=%h prs=%h chg=%h want %h %h %h %h",
                         cyc, btn_out, sw_out, btn_press, sw_change,
                         exp_btn, exp_sw, exp_press, exp_chg);
            end
        end
        checks++;
        if (pulses !== (EDGE_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL bounce_pulse_count got %0d want %0d", pulses, EDGE_EN ? 1 : 0);
        end
    endtask

    task automatic test_glitch();
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 27; i++) begin
            if (i == 7) btn_raw[2] = 1'b1;
            step();
            checks++;
            if ({btn_out, btn_press} !== {exp_btn, exp_press}) begin
                errors++;
                $display("FAIL glitch cyc=%0d got btn_out=%h btn_press=%h want %h %h",
                         cyc, btn_out, btn_press, exp_btn, exp_press);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        int t0;
        sw_raw[9] = 1'b1;
        repeat (5) step();
        rgm_reset = 1'b1;
        step();
        rgm_reset = 1'b0;
        checks++;
        if (sw_out[9] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear cyc=%0d got sw_out[9]=%b want 0", cyc, sw_out[9]);
        end
        t0 = cyc + 1;
        push_ev(t0 + LAT, F_SW, 9, 1'b1);
        push_pulse(t0 + LAT + 1, F_CHG, 9);
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if ({btn_out, sw_out, btn_press, sw_change} !== {exp_btn, exp_sw, exp_press, exp_chg})
            begin
                errors++;
                $display("FAIL mid_reset cyc=%0d got btn=%h sw=%h prs=%h chg=%h want %h %h %h %h",
                         cyc, btn_out, sw_out, btn_press, sw_change,
                         exp_btn, exp_sw, exp_press, exp_chg);
            end
        end
    endtask

    task automatic test_drain();
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL drain pending expectations=%0d want 0", evq.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press("clean_press");
        test_bounce();
        test_glitch();
        test_reset_mid_settle();
        test_clean_press("press_repeat");
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
